// File: rtl/controle_portas_n_if.sv
// rtl/controle_portas_n_if.sv - door controller sensor/indicator bundle
//
// Purpose: groups the per-door sensors, the guard release and all
// indicator outputs of controle_portas_n into one bundle.
// Ports (signals):
//   giro, entrada, saida, dec_metais [NUM_PORTAS]  sensors, master -> slave
//   liberar                                        guard release, master -> slave
//   led_verde, led_vermelho [NUM_PORTAS]           door indicators, slave -> master
//   ocupacao [W_CONT], lotado, alarme              room status, slave -> master
//   display [7]                                    active-low {g,f,e,d,c,b,a}, slave -> master
interface controle_portas_n_if #(
  parameter int NUM_PORTAS = 2,
  parameter int W_CONT     = 4
);
  logic [NUM_PORTAS-1:0] giro;
  logic [NUM_PORTAS-1:0] entrada;
  logic [NUM_PORTAS-1:0] saida;
  logic [NUM_PORTAS-1:0] dec_metais;
  logic                  liberar;
  logic [NUM_PORTAS-1:0] led_verde;
  logic [NUM_PORTAS-1:0] led_vermelho;
  logic [W_CONT-1:0]     ocupacao;
  logic                  lotado;
  logic                  alarme;
  logic [6:0]            display;

  modport master (
    output giro, entrada, saida, dec_metais, liberar,
    input  led_verde, led_vermelho, ocupacao, lotado, alarme, display
  );

  modport slave (
    input  giro, entrada, saida, dec_metais, liberar,
    output led_verde, led_vermelho, ocupacao, lotado, alarme, display
  );
endinterface

// File: rtl/controle_portas_n.sv
// rtl/controle_portas_n.sv - access controller for revolving security doors
//
// Purpose: one passage state machine per door (idle, entering, exiting,
// locked), a shared clamped occupancy counter, a per-door lockout timer
// started by metal detection, a global alarm and a guard release.
// Ports:
//   clock    system clock, all logic on posedge
//   reset_n  synchronous active-low reset
//   bus      controle_portas_n_if.slave: sensors in, LEDs/occupancy/display out
module controle_portas_n #(
  parameter int NUM_PORTAS     = 2,
  parameter int CAP_MAX        = 9,
  parameter int W_CONT         = 4,
  parameter int TEMPO_BLOQUEIO = 50
) (
  input  logic                 clock,
  input  logic                 reset_n,
  controle_portas_n_if.slave   bus
);

  localparam int W_TMP = (TEMPO_BLOQUEIO < 2) ? 1 : $clog2(TEMPO_BLOQUEIO + 1);

  typedef enum logic [1:0] {
    OCIOSO    = 2'd0,
    ENTRANDO  = 2'd1,
    SAINDO    = 2'd2,
    BLOQUEADO = 2'd3
  } estado_t;

  estado_t               estado_q [NUM_PORTAS];
  estado_t               estado_d [NUM_PORTAS];
  logic [W_TMP-1:0]      timer_q  [NUM_PORTAS];
  logic [W_TMP-1:0]      timer_d  [NUM_PORTAS];
  logic [NUM_PORTAS-1:0] recusa_q, recusa_d;
  logic [NUM_PORTAS-1:0] alarme_q, alarme_d;
  logic [NUM_PORTAS-1:0] entrou, saiu;
  logic [W_CONT-1:0]     ocup_q, ocup_d;
  logic                  lotado;
  logic [3:0]            nibble;
  logic [NUM_PORTAS-1:0] led_verde, led_vermelho;
  logic [6:0]            display;

  assign lotado = (ocup_q == W_CONT'(CAP_MAX));

  // Per-door passage FSMs. entrou/saiu flag a passage completing on this edge.
  always_comb begin
    for (int i = 0; i < NUM_PORTAS; i++) begin
      estado_d[i] = estado_q[i];
      timer_d[i]  = timer_q[i];
      recusa_d[i] = 1'b0;
      alarme_d[i] = 1'b0;
      entrou[i]   = 1'b0;
      saiu[i]     = 1'b0;
      unique case (estado_q[i])
        OCIOSO: begin
          if (bus.giro[i] && bus.entrada[i] && !bus.saida[i]) begin
            if (bus.dec_metais[i]) begin
              estado_d[i] = BLOQUEADO;
              timer_d[i]  = W_TMP'(TEMPO_BLOQUEIO);
            end else if (!lotado) begin
              estado_d[i] = ENTRANDO;
            end else begin
              // Refused while full: red LED held as long as the request is.
              recusa_d[i] = 1'b1;
            end
          end else if (bus.giro[i] && bus.saida[i] && !bus.entrada[i] &&
                       (ocup_q != '0)) begin
            estado_d[i] = SAINDO;
          end
        end
        ENTRANDO: begin
          if (bus.dec_metais[i]) begin
            estado_d[i] = BLOQUEADO;
            timer_d[i]  = W_TMP'(TEMPO_BLOQUEIO);
          end else if (!bus.giro[i]) begin
            estado_d[i] = OCIOSO;
            entrou[i]   = 1'b1;
          end
        end
        SAINDO: begin
          if (!bus.giro[i]) begin
            estado_d[i] = OCIOSO;
            saiu[i]     = 1'b1;
          end
        end
        BLOQUEADO: begin
          if (bus.liberar) begin
            estado_d[i] = OCIOSO;
            timer_d[i]  = '0;
          end else if (timer_q[i] != '0) begin
            timer_d[i] = timer_q[i] - 1'b1;
          end else if (!bus.dec_metais[i]) begin
            estado_d[i] = OCIOSO;
          end else begin
            // Lockout expired with metal still present.
            alarme_d[i] = 1'b1;
          end
        end
        default: estado_d[i] = OCIOSO;
      endcase
    end
  end

  // Occupancy: sum all completions of this edge, then clamp. Concurrent
  // admissions are decided on the registered count and may overshoot.
  always_comb begin
    int soma;
    soma = int'(ocup_q);
    for (int i = 0; i < NUM_PORTAS; i++) begin
      soma = soma + int'(entrou[i]) - int'(saiu[i]);
    end
    if (soma < 0) begin
      soma = 0;
    end else if (soma > CAP_MAX) begin
      soma = CAP_MAX;
    end
    ocup_d = W_CONT'(soma);
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_PORTAS; i++) begin
        estado_q[i] <= OCIOSO;
        timer_q[i]  <= '0;
      end
      recusa_q <= '0;
      alarme_q <= '0;
      ocup_q   <= '0;
    end else begin
      for (int i = 0; i < NUM_PORTAS; i++) begin
        estado_q[i] <= estado_d[i];
        timer_q[i]  <= timer_d[i];
      end
      recusa_q <= recusa_d;
      alarme_q <= alarme_d;
      ocup_q   <= ocup_d;
    end
  end

  always_comb begin
    led_verde    = '0;
    led_vermelho = '0;
    for (int i = 0; i < NUM_PORTAS; i++) begin
      led_verde[i]    = (estado_q[i] == ENTRANDO) || (estado_q[i] == SAINDO);
      led_vermelho[i] = (estado_q[i] == BLOQUEADO) || recusa_q[i];
    end
  end

  assign nibble = 4'(ocup_q);

  always_comb begin
    display = 7'b1000000;
    unique case (nibble)
      4'h0: display = 7'b1000000;
      4'h1: display = 7'b1111001;
      4'h2: display = 7'b0100100;
      4'h3: display = 7'b0110000;
      4'h4: display = 7'b0011001;
      4'h5: display = 7'b0010010;
      4'h6: display = 7'b0000010;
      4'h7: display = 7'b1111000;
      4'h8: display = 7'b0000000;
      4'h9: display = 7'b0010000;
      4'hA: display = 7'b0001000;
      4'hB: display = 7'b0000011;
      4'hC: display = 7'b1000110;
      4'hD: display = 7'b0100001;
      4'hE: display = 7'b0000110;
      4'hF: display = 7'b0001110;
      default: display = 7'b1000000;
    endcase
  end

  assign bus.led_verde    = led_verde;
  assign bus.led_vermelho = led_vermelho;
  assign bus.ocupacao     = ocup_q;
  assign bus.lotado       = lotado;
  assign bus.alarme       = |alarme_q;
  assign bus.display      = display;

endmodule

// File: tb/tb_controle_portas_n.sv
// tb/tb_controle_portas_n.sv - directed self-checking bench for controle_portas_n
module tb_controle_portas_n;

  logic clock;
  logic reset_n;
  int   n_checks;
  int   n_errors;

  controle_portas_n_if #(.NUM_PORTAS(2), .W_CONT(4)) bus ();

  controle_portas_n #(
    .NUM_PORTAS    (2),
    .CAP_MAX       (3),
    .W_CONT        (4),
    .TEMPO_BLOQUEIO(5)
  ) dut (
    .clock  (clock),
    .reset_n(reset_n),
    .bus    (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic verifica(input string tag, input logic [31:0] obs, input logic [31:0] esp);
    n_checks++;
    if (obs !== esp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, esp);
    end
  endtask

  // Advance one edge; outputs are sampled 1 time unit after it.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic limpa();
    bus.giro       = 2'b00;
    bus.entrada    = 2'b00;
    bus.saida      = 2'b00;
    bus.dec_metais = 2'b00;
    bus.liberar    = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;

    // Reset with every input high
    reset_n        = 1'b0;
    bus.giro       = 2'b11;
    bus.entrada    = 2'b11;
    bus.saida      = 2'b11;
    bus.dec_metais = 2'b11;
    bus.liberar    = 1'b1;
    tick();
    tick();
    verifica("rst_verde",    32'(bus.led_verde),    32'h0);
    verifica("rst_vermelho", 32'(bus.led_vermelho), 32'h0);
    verifica("rst_ocup",     32'(bus.ocupacao),     32'h0);
    verifica("rst_alarme",   32'(bus.alarme),       32'h0);
    verifica("rst_lotado",   32'(bus.lotado),       32'h0);
    verifica("rst_display",  32'(bus.display),      32'b1000000);
    limpa();
    reset_n = 1'b1;
    tick();

    // Entry on door 0
    bus.giro[0] = 1'b1; bus.entrada[0] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      verifica("ent_verde_on", 32'(bus.led_verde), 32'b01);
    end
    limpa();
    tick();
    verifica("ent_verde_off", 32'(bus.led_verde), 32'b00);
    verifica("ent_ocup",      32'(bus.ocupacao),  32'd1);
    verifica("ent_display",   32'(bus.display),   32'b1111001);

    // Metal on door 1: locked for 5 cycles, then alarm
    bus.giro[1] = 1'b1; bus.entrada[1] = 1'b1; bus.dec_metais[1] = 1'b1;
    tick();
    verifica("met_vermelho", 32'(bus.led_vermelho), 32'b10);
    verifica("met_verde",    32'(bus.led_verde),    32'b00);
    for (int k = 0; k < 5; k++) begin
      tick();
      verifica("met_alarme_low", 32'(bus.alarme), 32'h0);
    end
    tick();
    verifica("met_alarme_high", 32'(bus.alarme),       32'h1);
    verifica("met_ocup",        32'(bus.ocupacao),     32'd1);
    verifica("met_still_red",   32'(bus.led_vermelho), 32'b10);
    limpa();
    bus.liberar = 1'b1;
    tick();
    bus.liberar = 1'b0;
    verifica("lib_alarme",   32'(bus.alarme),       32'h0);
    verifica("lib_vermelho", 32'(bus.led_vermelho), 32'b00);

    // Two more entries fill the room (CAP_MAX=3)
    for (int k = 0; k < 2; k++) begin
      bus.giro[0] = 1'b1; bus.entrada[0] = 1'b1;
      tick();
      limpa();
      tick();
    end
    verifica("cap_ocup",    32'(bus.ocupacao), 32'd3);
    verifica("cap_lotado",  32'(bus.lotado),   32'h1);
    verifica("cap_display", 32'(bus.display),  32'b0110000);
    bus.giro[0] = 1'b1; bus.entrada[0] = 1'b1;
    tick();
    verifica("ref_vermelho", 32'(bus.led_vermelho), 32'b01);
    verifica("ref_verde",    32'(bus.led_verde),    32'b00);
    tick();
    verifica("ref_hold",     32'(bus.led_vermelho), 32'b01);
    limpa();
    tick();
    verifica("ref_drop",     32'(bus.led_vermelho), 32'b00);
    verifica("ref_ocup",     32'(bus.ocupacao),     32'd3);

    // One exit on door 1 -> 2
    bus.giro[1] = 1'b1; bus.saida[1] = 1'b1;
    tick();
    verifica("sai_verde", 32'(bus.led_verde), 32'b10);
    limpa();
    tick();
    verifica("sai_ocup", 32'(bus.ocupacao), 32'd2);

    // Simultaneous entry on door 0 and exit on door 1 -> stays 2
    bus.giro = 2'b11; bus.entrada[0] = 1'b1; bus.saida[1] = 1'b1;
    tick();
    verifica("sim_verde", 32'(bus.led_verde), 32'b11);
    limpa();
    tick();
    verifica("sim_ocup", 32'(bus.ocupacao), 32'd2);

    // Both doors admitted at 2: 4 clamps to 3
    bus.giro = 2'b11; bus.entrada = 2'b11;
    tick();
    verifica("clamp_verde", 32'(bus.led_verde), 32'b11);
    limpa();
    tick();
    verifica("clamp_ocup", 32'(bus.ocupacao), 32'd3);

    // Drain to 0: double exit then single exit
    bus.giro = 2'b11; bus.saida = 2'b11;
    tick();
    limpa();
    tick();
    verifica("drain1_ocup", 32'(bus.ocupacao), 32'd1);
    bus.giro[0] = 1'b1; bus.saida[0] = 1'b1;
    tick();
    limpa();
    tick();
    verifica("drain0_ocup", 32'(bus.ocupacao), 32'd0);

    // Exit request with empty room is refused
    bus.giro[0] = 1'b1; bus.saida[0] = 1'b1;
    tick();
    verifica("exit0_verde",   32'(bus.led_verde), 32'b00);
    tick();
    verifica("exit0_verde2",  32'(bus.led_verde), 32'b00);
    verifica("exit0_ocup",    32'(bus.ocupacao),  32'd0);
    verifica("exit0_display", 32'(bus.display),   32'b1000000);
    limpa();
    tick();

    // Reset mid-lockout (timer=3)
    bus.giro[0] = 1'b1; bus.entrada[0] = 1'b1; bus.dec_metais[0] = 1'b1;
    tick();
    verifica("rml_locked", 32'(bus.led_vermelho), 32'b01);
    tick();
    tick();
    reset_n = 1'b0;
    tick();
    verifica("rml_vermelho", 32'(bus.led_vermelho), 32'b00);
    verifica("rml_alarme",   32'(bus.alarme),       32'h0);
    verifica("rml_ocup",     32'(bus.ocupacao),     32'd0);
    limpa();
    reset_n = 1'b1;
    tick();
    verifica("rml_idle", 32'(bus.led_vermelho), 32'b00);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
